fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 153 +++++++++++++++
 tb/tb_fetch_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: Wishbone B4 master filling a DEPTH-entry {pc, ir, fault} queue.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic [1:0]  fault,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_stall
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [1:0]  fault;
    } entry_t;

    state_t        state;
    entry_t        q [DEPTH];
    entry_t        head, push_e;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, cnt_nxt;
    logic [31:0]   fetch_pc, drain_adr;
    logic          halted, halted_nxt;
    logic          resp_ack, resp_err, resp, push, pop, misalign, go_fetch;

    // A response arriving while IDLE (e.g. after a reset mid-cycle) is ignored.
    assign resp_ack = wb_ack_i && (state != IDLE);
    assign resp_err = wb_err_i && (state != IDLE);
    assign resp     = resp_ack || resp_err;
    assign misalign = jump_target[1:0] != 2'b00;
    assign pop      = ir_valid && ir_ready && !jump;

    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'hF;
    assign wb_adr_o = (state == DRAIN) ? drain_adr : fetch_pc;
    assign busy     = (state != IDLE);

    assign ir_valid = (count != '0);
    assign head     = q[rd_ptr];
    assign ir       = ir_valid ? head.ir    : 32'h0;
    assign pc       = ir_valid ? head.pc    : 32'h0;
    assign fault    = ir_valid ? head.fault : 2'b00;

    always_comb begin
        push   = 1'b0;
        push_e = '0;
        if (jump) begin
            push   = misalign;
            push_e = {jump_target, 32'h0, 2'b10};
        end else if (state == REQ && resp_ack) begin
            push   = 1'b1;
            push_e = {fetch_pc, wb_dat_i, 2'b00};
        end else if (state == REQ && resp_err) begin
            push   = 1'b1;
            push_e = {fetch_pc, 32'h0, 2'b01};
        end
    end

    // Next occupancy once any in-flight request has terminated this cycle.
    assign cnt_nxt    = jump ? CW'(push) : (count + CW'(push) - CW'(pop));
    assign halted_nxt = jump ? misalign : (halted || (state == REQ && resp_err));
    assign go_fetch   = !halted_nxt && (cnt_nxt < CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= push_e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wb_cyc_o  <= 1'b0;
            fetch_pc  <= RESET_PC;
            drain_adr <= RESET_PC;
            halted    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            halted <= halted_nxt;
            count  <= cnt_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (jump)     rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + 1'b1;

            if (jump)                           fetch_pc <= jump_target;
            else if (state == REQ && resp_ack)  fetch_pc <= fetch_pc + 32'd4;

            case (state)
                IDLE: if (go_fetch) begin
                    state    <= REQ;
                    wb_cyc_o <= 1'b1;
                end
                REQ: if (resp) begin
                    state    <= go_fetch ? REQ : IDLE;
                    wb_cyc_o <= go_fetch;
                end else if (jump) begin
                    state     <= DRAIN;
                    drain_adr <= fetch_pc;
                end
                DRAIN: if (resp) begin
                    state    <= go_fetch ? REQ : IDLE;
                    wb_cyc_o <= go_fetch;
                end
                default: begin
                    state    <= IDLE;
                    wb_cyc_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            if (state == REQ && resp_ack && !jump) perf_fetched <= perf_fetched + 32'd1;
            // Flushed entries plus any response thrown away by a jump or drain.
            perf_flushed <= perf_flushed + (jump ? 32'(count) : 32'd0)
                          + (((state == DRAIN) || (state == REQ && jump)) && resp ? 32'd1 : 32'd0);
            if (ir_ready && !ir_valid) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: transaction-level queue model plus directed scenarios.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i;
    logic        ir_valid, ir_ready = 1'b0;
    logic [31:0] ir, pc;
    logic [1:0]  fault;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .pc(pc), .fault(fault),
        .jump(jump), .jump_target(jump_target), .busy(busy)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Slave memory and wait-state/error behaviour
    int          slave_wait = 0, age = 0, ack_cnt = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0, last_ack_adr = 32'h0;
    logic        resp, is_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return a ^ 32'hDEAD_0000;
    endfunction

    assign resp     = wb_cyc_o && wb_stb_o && (age >= slave_wait);
    assign is_err   = err_en && (wb_adr_o == err_addr);
    assign wb_ack_i = resp && !is_err;
    assign wb_err_i = resp && is_err;
    assign wb_dat_i = mem_word(wb_adr_o);

    always @(posedge clk) begin
        if (wb_cyc_o && !resp) age <= age + 1;
        else                   age <= 0;
        if (wb_ack_i) begin
            ack_cnt      <= ack_cnt + 1;
            last_ack_adr <= wb_adr_o;
        end
    end

    // Behavioural model: queue of fetched words, next expected request address, drain tracking.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [1:0]  f;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] exp_adr = RESET_PC, drain_adr = 32'h0;
    bit          drain = 0, halted = 0, armed = 0;

    always @(negedge clk) if (armed) begin
        chk("m_ir_valid", 32'(ir_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_pc", pc, mq[0].pc);
            chk("m_ir", ir, mq[0].ir);
            chk("m_fault", 32'(fault), 32'(mq[0].f));
        end
        chk("m_busy", 32'(busy), 32'(wb_cyc_o));
        chk("m_stb", 32'(wb_stb_o), 32'(wb_cyc_o));
        chk("m_we_sel", {27'h0, wb_we_o, wb_sel_o}, 32'h0000_000F);
        if (wb_cyc_o) chk("m_adr", wb_adr_o, drain ? drain_adr : exp_adr);
        if (wb_cyc_o && !drain) chk("m_room", 32'(mq.size() < DEPTH), 32'h1);
        if (halted && !drain) chk("m_halt_idle", 32'(wb_cyc_o), 32'h0);

        if (rst) begin
            mq.delete();
            exp_adr = RESET_PC;
            drain = 0;
            halted = 0;
        end else if (jump) begin
            if (wb_cyc_o && !wb_ack_i && !wb_err_i) begin
                drain = 1;
                drain_adr = wb_adr_o;
            end else drain = 0;
            mq.delete();
            exp_adr = jump_target;
            halted = (jump_target[1:0] != 2'b00);
            if (halted) mq.push_back('{jump_target, 32'h0, 2'b10});
        end else begin
            if (ir_valid && ir_ready && mq.size() != 0) void'(mq.pop_front());
            if (drain) begin
                if (wb_ack_i || wb_err_i) drain = 0;
            end else if (wb_cyc_o && wb_ack_i) begin
                mq.push_back('{wb_adr_o, wb_dat_i, 2'b00});
                exp_adr = exp_adr + 32'd4;
            end else if (wb_cyc_o && wb_err_i) begin
                mq.push_back('{wb_adr_o, 32'h0, 2'b01});
                halted = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input logic [31:0] t);
        jump = 1'b1;
        jump_target = t;
        tick();
        jump = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] exp_pcs [4];
        exp_pcs[0] = 32'hFFFF_FFF8; exp_pcs[1] = 32'hFFFF_FFFC;
        exp_pcs[2] = 32'h0000_0000; exp_pcs[3] = 32'h0000_0004;

        // Reset state and first fetches
        repeat (3) tick();
        armed = 1;
        chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
        chk("rst_adr", wb_adr_o, RESET_PC);
        chk("rst_valid", 32'(ir_valid), 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        chk("first_cyc", 32'(wb_cyc_o), 32'h1);
        chk("first_adr", wb_adr_o, 32'h0);
        tick();
        chk("second_adr", wb_adr_o, 32'h4);
        chk("head_valid", 32'(ir_valid), 32'h1);
        chk("head_pc", pc, 32'h0);
        chk("head_ir", ir, 32'h0000_0013);
        chk("head_fault", 32'(fault), 32'h0);

        // Fill to DEPTH with no consumer, then one pop allows exactly one more fetch
        repeat (8) tick();
        chk("full_acks", 32'(ack_cnt), 32'd4);
        chk("full_last_adr", last_ack_adr, 32'hC);
        chk("full_cyc", 32'(wb_cyc_o), 32'h0);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        repeat (5) tick();
        chk("refill_acks", 32'(ack_cnt), 32'd5);
        chk("refill_adr", last_ack_adr, 32'h10);
        chk("refill_cyc", 32'(wb_cyc_o), 32'h0);
        chk("refill_head", pc, 32'h4);

        // Jump while a waited request to 0x8 is outstanding
        slave_wait = 3;
        ir_ready = 1'b1;
        do_jump(32'h0);
        n = 0;
        while (!(wb_cyc_o && wb_adr_o == 32'h8) && n < 50) begin tick(); n++; end
        chk("reach_8", 32'(n < 50), 32'h1);
        do_jump(32'h100);
        chk("drain_cyc", 32'(wb_cyc_o), 32'h1);
        chk("drain_adr", wb_adr_o, 32'h8);
        chk("drain_empty", 32'(ir_valid), 32'h0);
        n = 0;
        while (!wb_ack_i && n < 20) begin tick(); n++; end
        chk("drain_ack", 32'(n < 20), 32'h1);
        tick();
        chk("post_drain_cyc", 32'(wb_cyc_o), 32'h1);
        chk("post_drain_adr", wb_adr_o, 32'h100);
        chk("post_drain_empty", 32'(ir_valid), 32'h0);

        // Bus error at 0x40 halts fetching until the next jump
        slave_wait = 0;
        err_en = 1'b1;
        err_addr = 32'h40;
        do_jump(32'h30);
        n = 0;
        while (!(ir_valid && pc == 32'h40) && n < 50) begin tick(); n++; end
        chk("err_seen", 32'(n < 50), 32'h1);
        chk("err_fault", 32'(fault), 32'h1);
        chk("err_ir", ir, 32'h0);
        n = 0;
        repeat (6) begin tick(); if (wb_cyc_o) n++; end
        chk("err_halted", 32'(n), 32'h0);
        err_en = 1'b0;
        do_jump(32'h0);
        chk("resume_cyc", 32'(wb_cyc_o), 32'h1);
        chk("resume_adr", wb_adr_o, 32'h0);

        // Misaligned target produces one tagged entry and no bus access
        ir_ready = 1'b0;
        do_jump(32'h102);
        chk("mis_valid", 32'(ir_valid), 32'h1);
        chk("mis_pc", pc, 32'h102);
        chk("mis_fault", 32'(fault), 32'h2);
        chk("mis_ir", ir, 32'h0);
        n = 0;
        repeat (5) begin if (wb_cyc_o) n++; tick(); end
        chk("mis_no_bus", 32'(n), 32'h0);
        chk("mis_hold", pc, 32'h102);

        // Jump coinciding with an ack, then address wrap past 0xFFFF_FFFC
        do_jump(32'h200);
        chk("pre_ack", 32'(wb_ack_i), 32'h1);
        do_jump(32'hFFFF_FFF8);
        chk("ack_dropped", 32'(ir_valid), 32'h0);
        chk("wrap_cyc", 32'(wb_cyc_o), 32'h1);
        chk("wrap_adr0", wb_adr_o, 32'hFFFF_FFF8);
        n = 0;
        while (wb_cyc_o && n < 20) begin tick(); n++; end
        chk("wrap_full", 32'(n < 20), 32'h1);
        ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_pc", pc, exp_pcs[i]);
            tick();
        end

        // Reset during a waited bus cycle
        slave_wait = 5;
        do_jump(32'h80);
        tick();
        chk("midrst_pre", 32'(wb_cyc_o), 32'h1);
        rst = 1'b1;
        tick();
        chk("midrst_cyc", 32'(wb_cyc_o), 32'h0);
        chk("midrst_valid", 32'(ir_valid), 32'h0);
        chk("midrst_adr", wb_adr_o, RESET_PC);
        rst = 1'b0;
        slave_wait = 0;
        tick();
        chk("midrst_restart", 32'(wb_cyc_o), 32'h1);
        chk("midrst_adr0", wb_adr_o, RESET_PC);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
